// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous RAM between the 6502 core and the
// host/debug port (program load, memory inspection, DMA). Exactly one RAM
// access is issued per clock. The host wins a cycle whenever it requests and
// has not yet used up its burst allowance. Once it has, the CPU is given one
// forced cycle, so the core keeps making progress under continuous host
// traffic. The CPU is held off through a 6502-style RDY.
//
// Cycle owner
//   owner     | meaning
//   ----------+------------------------------------------------------------
//   OWN_CPU   | CPU address/data/RW drive the RAM, cpu_rdy=1
//   OWN_HOST  | host address/data/RW drive the RAM, host_ack=1, cpu_rdy=0
//
// owner_q remembers last cycle's owner. It tells us who asked for the data
// now on ram_D_out, because the RAM read is synchronous.
//
// Parameters
//   ADDR_W          RAM address width; CPU address is truncated to it
//   MAX_HOST_BURST  host cycles allowed back to back before a forced CPU
//                   cycle (1..15)
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   cpu_RW/cpu_AD/cpu_D_out     CPU access request (always presented)
//   cpu_D_in, cpu_rdy           CPU read data, cycle grant
//   host_req/RW/A/wdata         host access request, held until host_ack
//   host_ack                    host access issued this cycle (comb)
//   host_rvalid, host_rdata     host read return, one cycle after the read
//   ram_RW/ram_A/ram_D_in       RAM access outputs
//   ram_D_out                   RAM read data, valid the cycle after address
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int MAX_HOST_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_RW,
    input  logic [15:0]       cpu_AD,
    input  logic [7:0]        cpu_D_out,
    output logic [7:0]        cpu_D_in,
    output logic              cpu_rdy,

    input  logic              host_req,
    input  logic              host_RW,
    input  logic [ADDR_W-1:0] host_A,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [7:0]        host_rdata,

    output logic              ram_RW,
    output logic [ADDR_W-1:0] ram_A,
    output logic [7:0]        ram_D_in,
    input  logic [7:0]        ram_D_out
);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_HOST_BURST);

    owner_e      owner;
    owner_e      owner_q,       owner_d;
    logic [3:0]  burst_cnt_q,   burst_cnt_d;
    logic [7:0]  cpu_hold_q,    cpu_hold_d;
    logic        host_rvalid_q, host_rvalid_d;

    // Upper CPU address bits are ignored: the RAM only spans ADDR_W bits.
    generate
        if (ADDR_W < 16) begin : g_trunc
            logic unused_cpu_ad_hi;
            assign unused_cpu_ad_hi = ^cpu_AD[15:ADDR_W];
        end
    endgenerate

    // Cycle ownership and RAM mux. When the host owns the cycle, the CPU's
    // write is simply not routed to the RAM. The core re-presents it once
    // cpu_rdy returns, so no write can leak out during a stall.
    always_comb begin
        owner = (host_req && (burst_cnt_q < BURST_LIMIT)) ? OWN_HOST : OWN_CPU;

        if (owner == OWN_HOST) begin
            ram_RW   = host_RW;
            ram_A    = host_A;
            ram_D_in = host_wdata;
            host_ack = 1'b1;
            cpu_rdy  = 1'b0;
        end else begin
            ram_RW   = cpu_RW;
            ram_A    = cpu_AD[ADDR_W-1:0];
            ram_D_in = cpu_D_out;
            host_ack = 1'b0;
            cpu_rdy  = 1'b1;
        end
    end

    // Read-data steering. If the CPU owned last cycle, the RAM output is the
    // CPU's data and passes straight through. Otherwise the core is stalled
    // and sees the byte from its last own cycle, which cpu_hold keeps.
    always_comb begin
        cpu_D_in    = (owner_q == OWN_CPU) ? ram_D_out : cpu_hold_q;
        host_rdata  = ram_D_out;
        host_rvalid = host_rvalid_q;
    end

    always_comb begin
        owner_d       = owner;
        burst_cnt_d   = (owner == OWN_HOST) ? (burst_cnt_q + 4'd1) : 4'd0;
        host_rvalid_d = (owner == OWN_HOST) && host_RW;
        cpu_hold_d    = (owner_q == OWN_CPU) ? ram_D_out : cpu_hold_q;
    end

    // A reset in the middle of a host read clears host_rvalid_q, so no late
    // pulse appears after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q       <= OWN_CPU;
            burst_cnt_q   <= 4'd0;
            cpu_hold_q    <= 8'h00;
            host_rvalid_q <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            burst_cnt_q   <= burst_cnt_d;
            cpu_hold_q    <= cpu_hold_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a synchronous read-first RAM model.
// Host and CPU accesses come from two op queues. Each clock presents the head
// of each queue, and the head is popped when the expected owner grants it.
// Host read data is pushed to a scoreboard when the read is issued. It is
// popped when host_rvalid appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int MAXB   = 4;
    localparam logic [15:0] IDLE_A = 16'h0200;

    typedef struct packed {
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
    } op_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_RW;
    logic [15:0]       cpu_AD;
    logic [7:0]        cpu_D_out;
    logic [7:0]        cpu_D_in;
    logic              cpu_rdy;
    logic              host_req;
    logic              host_RW;
    logic [ADDR_W-1:0] host_A;
    logic [7:0]        host_wdata;
    logic              host_ack;
    logic              host_rvalid;
    logic [7:0]        host_rdata;
    logic              ram_RW;
    logic [ADDR_W-1:0] ram_A;
    logic [7:0]        ram_D_in;
    logic [7:0]        ram_D_out = 8'h00;

    logic [7:0] mem [0:1023] = '{default: 8'h00};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_D_out <= mem[ram_A];
        if (!ram_RW) mem[ram_A] <= ram_D_in;
    end

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_HOST_BURST(MAXB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_RW     (cpu_RW),
        .cpu_AD     (cpu_AD),
        .cpu_D_out  (cpu_D_out),
        .cpu_D_in   (cpu_D_in),
        .cpu_rdy    (cpu_rdy),
        .host_req   (host_req),
        .host_RW    (host_RW),
        .host_A     (host_A),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .ram_RW     (ram_RW),
        .ram_A      (ram_A),
        .ram_D_in   (ram_D_in),
        .ram_D_out  (ram_D_out)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_burst;
    logic       exp_rvalid;
    logic [7:0] exp_cpu_din;
    logic [7:0] shadow [0:1023];
    logic [7:0] rq[$];
    op_t        hq[$];
    op_t        cq[$];
    int         cyc, acks;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One step per clock, until both queues drain or the budget runs out.
    task automatic run(input int budget, output int cycles, output int n_ack);
        logic       hreq;
        logic       exp_host;
        op_t        h, c;
        logic [9:0] ca;
        cycles = 0;
        n_ack  = 0;
        while ((hq.size() > 0 || cq.size() > 0) && cycles < budget) begin
            hreq = (hq.size() > 0);
            h    = hreq ? hq[0] : {1'b1, 16'h0000, 8'h00};
            c    = (cq.size() > 0) ? cq[0] : {1'b1, IDLE_A, 8'h00};
            @(negedge clk);
            host_req   = hreq;
            host_RW    = h.rw;
            host_A     = h.a[9:0];
            host_wdata = h.d;
            cpu_RW     = c.rw;
            cpu_AD     = c.a;
            cpu_D_out  = c.d;
            #1;
            exp_host = hreq && (exp_burst < MAXB);
            ca       = c.a[9:0];
            chk("host_ack", 16'(host_ack), 16'(exp_host));
            chk("cpu_rdy", 16'(cpu_rdy), 16'(!exp_host));
            chk("ram_A", 16'(ram_A), 16'(exp_host ? h.a[9:0] : ca));
            chk("ram_RW", 16'(ram_RW), 16'(exp_host ? h.rw : c.rw));
            if ((exp_host && !h.rw) || (!exp_host && !c.rw))
                chk("ram_D_in", 16'(ram_D_in), 16'(exp_host ? h.d : c.d));
            chk("host_rvalid", 16'(host_rvalid), 16'(exp_rvalid));
            if (host_rvalid) begin
                if (rq.size() == 0) chk("rq_empty", 16'(rq.size()), 16'd1);
                else chk("host_rdata", 16'(host_rdata), 16'(rq.pop_front()));
            end
            chk("cpu_D_in", 16'(cpu_D_in), 16'(exp_cpu_din));
            if (exp_host) begin
                if (h.rw) rq.push_back(shadow[h.a[9:0]]);
                else      shadow[h.a[9:0]] = h.d;
                exp_rvalid = h.rw;
                exp_burst++;
                void'(hq.pop_front());
                n_ack++;
            end else begin
                exp_cpu_din = shadow[ca];
                if (!c.rw) shadow[ca] = c.d;
                exp_rvalid = 1'b0;
                exp_burst  = 0;
                if (cq.size() > 0) void'(cq.pop_front());
            end
            cycles++;
        end
        chk("run_done", 16'(hq.size() + cq.size()), 16'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n    = 1'b0;
        host_req = 1'b0;
        cpu_RW   = 1'b1;
        cpu_AD   = IDLE_A;
        #1;
        chk("rst_rvalid_drop", 16'(host_rvalid), 16'd0);
        chk("rst_cpu_rdy", 16'(cpu_rdy), 16'd1);
        rq.delete();
        @(negedge clk);
        #1;
        chk("rst_cpu_D_in", 16'(cpu_D_in), 16'h00);
        chk("rst_rvalid", 16'(host_rvalid), 16'd0);
        chk("rst_host_ack", 16'(host_ack), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_cpu_rdy", 16'(cpu_rdy), 16'd1);
        chk("rel_rvalid", 16'(host_rvalid), 16'd0);
        exp_burst   = 0;
        exp_rvalid  = 1'b0;
        exp_cpu_din = shadow[IDLE_A[9:0]];
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
        rst_n      = 1'b0;
        host_req   = 1'b0;
        host_RW    = 1'b1;
        host_A     = '0;
        host_wdata = 8'h00;
        cpu_RW     = 1'b1;
        cpu_AD     = IDLE_A;
        cpu_D_out  = 8'h00;
        exp_burst  = 0;
        exp_rvalid = 1'b0;
        exp_cpu_din = 8'h00;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_ack", 16'(host_ack), 16'd0);
        chk("reset_rdy", 16'(cpu_rdy), 16'd1);
        chk("reset_ram_RW", 16'(ram_RW), 16'(cpu_RW));
        chk("reset_rvalid", 16'(host_rvalid), 16'd0);
        chk("reset_cpu_D_in", 16'(cpu_D_in), 16'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Program load by host: NOP; LDA #$55; ADC #$03; AND #$F0
        hq.push_back({1'b0, 16'h0000, 8'hEA});
        hq.push_back({1'b0, 16'h0001, 8'hA9});
        hq.push_back({1'b0, 16'h0002, 8'h55});
        hq.push_back({1'b0, 16'h0003, 8'h69});
        hq.push_back({1'b0, 16'h0004, 8'h03});
        hq.push_back({1'b0, 16'h0005, 8'h29});
        hq.push_back({1'b0, 16'h0006, 8'hF0});
        run(40, cyc, acks);
        chk("load_cycles", 16'(cyc), 16'd8);
        chk("load_acks", 16'(acks), 16'd7);

        // CPU only: fetch with high address bits set (truncation)
        for (int i = 0; i < 7; i++) cq.push_back({1'b1, 16'hFC00 + 16'(i), 8'h00});
        run(40, cyc, acks);
        chk("cpu_only_cycles", 16'(cyc), 16'd7);
        chk("cpu_only_acks", 16'(acks), 16'd0);

        // Host write then read at the top address
        hq.push_back({1'b0, 16'h03FF, 8'hA5});
        hq.push_back({1'b1, 16'h03FF, 8'h00});
        run(40, cyc, acks);
        chk("wr_rd_acks", 16'(acks), 16'd2);
        cq.push_back({1'b1, 16'h0000, 8'h00});
        run(40, cyc, acks);

        // Continuous host traffic, alternating write/read at $010/$011,
        // while the CPU fetches 4 program bytes
        for (int k = 0; k < 8; k++) begin
            hq.push_back({1'b0, ((k % 2) != 0) ? 16'h0011 : 16'h0010, 8'h10 + 8'(k)});
            hq.push_back({1'b1, ((k % 2) != 0) ? 16'h0011 : 16'h0010, 8'h00});
        end
        for (int i = 0; i < 4; i++) cq.push_back({1'b1, 16'(i), 8'h00});
        run(60, cyc, acks);
        chk("burst_cycles", 16'(cyc), 16'd20);
        chk("burst_acks", 16'(acks), 16'd16);

        // CPU reads $001, then stalls across 3 host reads with a write queued
        cq.push_back({1'b1, 16'h0001, 8'h00});
        run(40, cyc, acks);
        for (int i = 0; i < 3; i++) hq.push_back({1'b1, 16'h03FF, 8'h00});
        cq.push_back({1'b0, 16'h0100, 8'h77});
        cq.push_back({1'b1, 16'h0100, 8'h00});
        run(40, cyc, acks);
        chk("stall_cycles", 16'(cyc), 16'd5);
        chk("stall_wr_landed", 16'(shadow[10'h100]), 16'h77);

        // Reset the cycle after a host read ack
        hq.push_back({1'b1, 16'h03FF, 8'h00});
        run(40, cyc, acks);
        reset_pulse();

        // burst counter restarted from zero: 4 host, 1 CPU, 1 host
        for (int i = 0; i < 5; i++) hq.push_back({1'b1, 16'h0010 + 16'(i % 2), 8'h00});
        cq.push_back({1'b1, 16'h0005, 8'h00});
        run(40, cyc, acks);
        chk("post_rst_cycles", 16'(cyc), 16'd6);
        cq.push_back({1'b1, 16'h0006, 8'h00});
        cq.push_back({1'b1, 16'h0100, 8'h00});
        run(40, cyc, acks);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
